// File: rtl/tpa_pkg.sv
// Shared types and constants for the dual-access register bank.
package tpa_pkg;

  typedef enum logic {C_IDLE, C_ACK} cfg_state_e;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_COMMIT,
    S_TURN, S_PRE1, S_PRE0, S_RDATA, S_STOP
  } tw_state_e;

  localparam logic CMD_WRITE  = 1'b1;
  localparam logic CMD_READ   = 1'b0;
  localparam int   TURN_TICKS = 2;
  localparam logic PRE1_LVL   = 1'b1;
  localparam logic PRE0_LVL   = 1'b0;
  localparam logic STOP_LVL   = 1'b1;

  function automatic logic in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/tpa_tick_gen.sv
// Serial bit tick: every clk, or one clk per synchronised SCL rising edge.
module tpa_tick_gen #(
  parameter bit USE_SCL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl,
  input  logic sda_in,
  output logic tick,
  output logic sda_smp
);

  logic [2:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], scl};
    sda_sync_d = {sda_sync_q[0], sda_in};
  end

  // SDA rides the same two-flop depth as SCL so the sampled bit lines up with the tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= '0;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
    end
  end

  always_comb begin
    tick    = USE_SCL ? (scl_sync_q[1] & ~scl_sync_q[2]) : 1'b1;
    sda_smp = USE_SCL ? sda_sync_q[1] : sda_in;
  end

endmodule

// File: rtl/tpa_regbank_param.sv
// Register array shared by a cfg request/ack port and a two-wire serial port.
// state    | meaning
// C_IDLE   | cfg: waiting for request      C_ACK   | cfg: rdy pulse
// S_IDLE   | serial: wait start bit        S_CMD   | r/w bit
// S_ADDR   | address bits, LSB first       S_WDATA | write data bits
// S_COMMIT | write or drop                 S_TURN  | bus released
// S_PRE1   | drive 1                       S_PRE0  | drive 0
// S_RDATA  | snapshot bits, LSB first      S_STOP  | drive 1, then release
module tpa_regbank_param
  import tpa_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int DEPTH    = 256,
  parameter bit USE_SCL  = 1'b0,
  parameter bit CFG_WINS = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          SCL,
  inout  wire           SDA,
  input  logic          cfg_req,
  input  logic          cfg_cmd,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_wdata,
  output logic          cfg_rdy,
  output logic [DW-1:0] cfg_rdata,
  output logic          tw_busy,
  output logic          tw_drop
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DW) + 1;
  localparam logic [CW-1:0] ADDR_LAST = CW'(AW - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_TICKS - 1);

  logic tick, sda_smp;

  tpa_tick_gen #(.USE_SCL(USE_SCL)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .scl     (SCL),
    .sda_in  (SDA),
    .tick    (tick),
    .sda_smp (sda_smp)
  );

  logic [DW-1:0] mem_q [DEPTH];

  cfg_state_e    cst_q, cst_d;
  logic [DW-1:0] cfg_rdata_q, cfg_rdata_d;
  tw_state_e     tst_q, tst_d;
  logic          is_wr_q, is_wr_d;
  logic [AW-1:0] tw_addr_q, tw_addr_d;
  logic [DW-1:0] tw_data_q, tw_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sda_o_q, sda_o_d, sda_oe_q, sda_oe_d;
  logic [DEPTH-1:0] dirty_q, dirty_d;

  logic          cfg_acc, cfg_ok, cfg_wr, tw_ok, start, conflict, commit_drop, commit_we;
  logic [IW-1:0] cfg_idx, tw_idx;

  always_comb begin
    cfg_idx     = cfg_addr[IW-1:0];
    tw_idx      = tw_addr_q[IW-1:0];
    cfg_ok      = in_range(32'(cfg_addr), DEPTH);
    tw_ok       = in_range(32'(tw_addr_q), DEPTH);
    cfg_acc     = (cst_q == C_IDLE) && cfg_req;
    cfg_wr      = cfg_acc && (cfg_cmd == CMD_WRITE) && cfg_ok;
    start       = (tst_q == S_IDLE) && tick && !sda_smp;
    // A cfg write landing in the commit cycle itself still counts as a conflict.
    conflict    = dirty_q[tw_idx] | (cfg_wr && (cfg_idx == tw_idx));
    commit_drop = !tw_ok || (CFG_WINS && conflict);
    commit_we   = (tst_q == S_COMMIT) && !commit_drop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cst_q       <= C_IDLE;
      cfg_rdata_q <= '0;
      tst_q       <= S_IDLE;
      is_wr_q     <= 1'b0;
      tw_addr_q   <= '0;
      tw_data_q   <= '0;
      cnt_q       <= '0;
      sda_o_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      dirty_q     <= '0;
    end else begin
      cst_q       <= cst_d;
      cfg_rdata_q <= cfg_rdata_d;
      tst_q       <= tst_d;
      is_wr_q     <= is_wr_d;
      tw_addr_q   <= tw_addr_d;
      tw_data_q   <= tw_data_d;
      cnt_q       <= cnt_d;
      sda_o_q     <= sda_o_d;
      sda_oe_q    <= sda_oe_d;
      dirty_q     <= dirty_d;
    end
  end

  // Serial commit is ordered last so it wins a same-address collision when it is allowed to write.
  always_ff @(posedge clk) begin
    if (cfg_wr)    mem_q[cfg_idx] <= cfg_wdata;
    if (commit_we) mem_q[tw_idx]  <= tw_data_q;
  end

  always_comb begin
    cst_d       = (cst_q == C_IDLE) ? (cfg_req ? C_ACK : C_IDLE) : C_IDLE;
    cfg_rdata_d = cfg_rdata_q;
    if (cfg_acc && (cfg_cmd == CMD_READ)) cfg_rdata_d = cfg_ok ? mem_q[cfg_idx] : '0;
  end

  always_comb begin
    tst_d     = tst_q;
    is_wr_d   = is_wr_q;
    tw_addr_d = tw_addr_q;
    tw_data_d = tw_data_q;
    cnt_d     = cnt_q;
    sda_o_d   = sda_o_q;
    sda_oe_d  = sda_oe_q;
    dirty_d   = dirty_q;
    if (start) dirty_d = '0;
    if (cfg_wr && (start || tst_q != S_IDLE)) dirty_d[cfg_idx] = 1'b1;
    case (tst_q)
      S_IDLE: if (start) tst_d = S_CMD;
      S_CMD: if (tick) begin
        is_wr_d = sda_smp;
        cnt_d   = '0;
        tst_d   = S_ADDR;
      end
      S_ADDR: if (tick) begin
        tw_addr_d = {sda_smp, tw_addr_q[AW-1:1]};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == ADDR_LAST) begin
          cnt_d = '0;
          tst_d = is_wr_q ? S_WDATA : S_TURN;
        end
      end
      S_WDATA: if (tick) begin
        tw_data_d = {sda_smp, tw_data_q[DW-1:1]};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == DATA_LAST) tst_d = S_COMMIT;
      end
      S_COMMIT: tst_d = S_IDLE;
      S_TURN: if (tick) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TURN_LAST) begin
          tst_d     = S_PRE1;
          tw_data_d = tw_ok ? mem_q[tw_idx] : '0;
          sda_o_d   = PRE1_LVL;
          sda_oe_d  = 1'b1;
        end
      end
      S_PRE1: if (tick) begin
        tst_d   = S_PRE0;
        sda_o_d = PRE0_LVL;
      end
      S_PRE0: if (tick) begin
        tst_d     = S_RDATA;
        sda_o_d   = tw_data_q[0];
        tw_data_d = tw_data_q >> 1;
        cnt_d     = '0;
      end
      S_RDATA: if (tick) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DATA_LAST) begin
          tst_d   = S_STOP;
          sda_o_d = STOP_LVL;
        end else begin
          sda_o_d   = tw_data_q[0];
          tw_data_d = tw_data_q >> 1;
        end
      end
      S_STOP: if (tick) begin
        tst_d    = S_IDLE;
        sda_o_d  = 1'b0;
        sda_oe_d = 1'b0;
      end
      default: tst_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_rdy   = (cst_q == C_ACK);
    cfg_rdata = cfg_rdata_q;
    tw_busy   = (tst_q != S_IDLE);
    tw_drop   = (tst_q == S_COMMIT) && commit_drop;
  end

  assign SDA = sda_oe_q ? sda_o_q : 1'bz;

endmodule

// File: tb/tb_tpa_regbank_param.sv
// Bench for tpa_regbank_param: instance a uses defaults, instance b uses DEPTH=128, USE_SCL=1, CFG_WINS=0.
module tb_tpa_regbank_param;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        scl;
  logic        cfg_req, cfg_cmd;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        tb_oe, tb_sda, sel_b;

  wire         sda_a, sda_b;
  logic        rdy_a, rdy_b, busy_a, busy_b, drop_a, drop_b;
  logic [15:0] rdata_a, rdata_b;

  int n_tests = 0;
  int n_fail  = 0;
  int drop_cnt_a = 0;
  int drop_cnt_b = 0;

  logic [15:0] cfg_exp_q [$];
  logic [1:0]  ser_exp_q [$];

  assign sda_a = sel_b  ? 1'b1 : (tb_oe ? tb_sda : 1'bz);
  assign sda_b = !sel_b ? 1'b1 : (tb_oe ? tb_sda : 1'bz);

  always #5 clk = ~clk;

  tpa_regbank_param dut_a (
    .clk(clk), .reset_n(reset_n), .SCL(scl), .SDA(sda_a),
    .cfg_req(cfg_req), .cfg_cmd(cfg_cmd), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdy(rdy_a), .cfg_rdata(rdata_a), .tw_busy(busy_a), .tw_drop(drop_a)
  );

  tpa_regbank_param #(.AW(8), .DW(16), .DEPTH(128), .USE_SCL(1'b1), .CFG_WINS(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .SCL(scl), .SDA(sda_b),
    .cfg_req(cfg_req), .cfg_cmd(cfg_cmd), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdy(rdy_b), .cfg_rdata(rdata_b), .tw_busy(busy_b), .tw_drop(drop_b)
  );

  always @(negedge clk) begin
    if (drop_a) drop_cnt_a++;
    if (drop_b) drop_cnt_b++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cfg_op(input bit b, input bit cmd, input logic [7:0] addr,
                        input logic [15:0] wd, input string name);
    int lat;
    bit got;
    logic [15:0] exp;
    cfg_cmd = cmd; cfg_addr = addr; cfg_wdata = wd; cfg_req = 1'b1;
    n_tests++;
    if ((b ? rdy_b : rdy_a) !== 1'b0) begin
      n_fail++; $display("FAIL %s pre-accept rdy: got 1 expected 0", name);
    end
    lat = 0; got = 0;
    while (!got && lat < 10) begin
      @(posedge clk); #1; lat++;
      if ((b ? rdy_b : rdy_a) === 1'b1) got = 1;
    end
    cfg_req = 1'b0;
    n_tests++;
    if (!got || lat != 1) begin
      n_fail++; $display("FAIL %s rdy latency: got %0d cycles expected 1", name, lat);
    end
    if (cmd == 1'b0) begin
      n_tests++;
      if (cfg_exp_q.size() == 0) begin
        n_fail++; $display("FAIL %s scoreboard empty", name);
      end else begin
        exp = cfg_exp_q.pop_front();
        if ((b ? rdata_b : rdata_a) !== exp) begin
          n_fail++; $display("FAIL %s rdata: got %h expected %h", name, (b ? rdata_b : rdata_a), exp);
        end
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if ((b ? rdy_b : rdy_a) !== 1'b0) begin
      n_fail++; $display("FAIL %s rdy pulse width: got 1 expected 0", name);
    end
  endtask

  task automatic cfg_read(input bit b, input logic [7:0] addr, input logic [15:0] exp, input string name);
    cfg_exp_q.push_back(exp);
    cfg_op(b, 1'b0, addr, 16'h0, name);
  endtask

  task automatic ser_bit(input bit b, input bit v);
    tb_sda = v;
    if (!b) begin
      @(posedge clk); #1;
    end else begin
      scl = 1'b0; repeat (4) @(posedge clk); #1;
      scl = 1'b1; repeat (4) @(posedge clk); #1;
    end
  endtask

  task automatic ser_frame(input bit b, input bit wr, input logic [7:0] a, input logic [15:0] d);
    sel_b = b; tb_oe = 1'b1;
    ser_bit(b, 1'b0);
    ser_bit(b, wr);
    for (int i = 0; i < 8; i++) ser_bit(b, a[i]);
    if (wr) begin
      for (int i = 0; i < 16; i++) ser_bit(b, d[i]);
      tb_sda = 1'b1;
    end else begin
      tb_oe = 1'b0;
    end
  endtask

  task automatic push_read_exp(input logic [15:0] v);
    ser_exp_q.push_back(2'd2); ser_exp_q.push_back(2'd2);
    ser_exp_q.push_back(2'd1); ser_exp_q.push_back(2'd0);
    for (int i = 0; i < 16; i++) ser_exp_q.push_back({1'b0, v[i]});
    ser_exp_q.push_back(2'd1); ser_exp_q.push_back(2'd2);
  endtask

  // Code 2 means released; otherwise the driven level.
  task automatic ser_observe(input bit b, input int n, input bit redrive, input string name);
    logic [1:0] obs, exp;
    for (int i = 0; i < n; i++) begin
      if (!b) @(negedge clk);
      else begin scl = 1'b0; repeat (4) @(posedge clk); #1; end
      if (b) obs = dut_b.sda_oe_q ? {1'b0, sda_b} : 2'd2;
      else   obs = dut_a.sda_oe_q ? {1'b0, sda_a} : 2'd2;
      exp = ser_exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL %s sda step %0d: got %0d expected %0d", name, i, obs, exp);
      end
      if (redrive && i == n - 1) begin tb_oe = 1'b1; tb_sda = 1'b1; end
      if (b) begin scl = 1'b1; repeat (4) @(posedge clk); #1; end
    end
    if (!b) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    n_tests++;
    if ({rdy_a, rdy_b, busy_a, busy_b, drop_a, drop_b} !== 6'b0) begin
      n_fail++; $display("FAIL reset flags: got %b expected 000000", {rdy_a, rdy_b, busy_a, busy_b, drop_a, drop_b});
    end
    n_tests++;
    if (rdata_a !== 16'h0 || rdata_b !== 16'h0) begin
      n_fail++; $display("FAIL reset rdata: got %h/%h expected 0000/0000", rdata_a, rdata_b);
    end
    n_tests++;
    if (dut_a.sda_oe_q !== 1'b0 || dut_b.sda_oe_q !== 1'b0) begin
      n_fail++; $display("FAIL reset sda release: got oe %b/%b expected 0/0", dut_a.sda_oe_q, dut_b.sda_oe_q);
    end
  endtask

  task automatic test_cfg_rw;
    cfg_op(1'b0, 1'b1, 8'h12, 16'hBEEF, "cfg_wr_12");
    cfg_read(1'b0, 8'h12, 16'hBEEF, "cfg_rd_12");
    cfg_op(1'b0, 1'b1, 8'h13, 16'h0001, "cfg_wr_13");
    n_tests++;
    if (rdata_a !== 16'hBEEF) begin
      n_fail++; $display("FAIL cfg_rdata_hold: got %h expected beef", rdata_a);
    end
  endtask

  task automatic test_serial_write;
    int d0;
    d0 = drop_cnt_a;
    ser_frame(1'b0, 1'b1, 8'h34, 16'hA5A5);
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (drop_cnt_a != d0) begin
      n_fail++; $display("FAIL ser_wr_drop: got %0d pulses expected 0", drop_cnt_a - d0);
    end
    cfg_read(1'b0, 8'h34, 16'hA5A5, "ser_wr_34");
  endtask

  task automatic test_serial_read;
    ser_frame(1'b0, 1'b0, 8'h12, 16'h0);
    n_tests++;
    if (busy_a !== 1'b1) begin
      n_fail++; $display("FAIL ser_rd_busy_mid: got %b expected 1", busy_a);
    end
    push_read_exp(16'hBEEF);
    ser_observe(1'b0, 22, 1'b1, "ser_rd_a");
    n_tests++;
    if (busy_a !== 1'b0) begin
      n_fail++; $display("FAIL ser_rd_busy_end: got %b expected 0", busy_a);
    end
  endtask

  task automatic test_conflict;
    int d0;
    d0 = drop_cnt_a;
    fork
      ser_frame(1'b0, 1'b1, 8'h40, 16'h1111);
      begin repeat (10) @(posedge clk); #1; cfg_op(1'b0, 1'b1, 8'h40, 16'h2222, "cfg_mid_a"); end
    join
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (drop_cnt_a != d0 + 1) begin
      n_fail++; $display("FAIL conflict_drop_a: got %0d pulses expected 1", drop_cnt_a - d0);
    end
    cfg_read(1'b0, 8'h40, 16'h2222, "conflict_a");
    d0 = drop_cnt_b;
    fork
      ser_frame(1'b1, 1'b1, 8'h40, 16'h1111);
      begin repeat (40) @(posedge clk); #1; cfg_op(1'b1, 1'b1, 8'h40, 16'h2222, "cfg_mid_b"); end
    join
    repeat (4) @(posedge clk); #1;
    n_tests++;
    if (drop_cnt_b != d0) begin
      n_fail++; $display("FAIL conflict_drop_b: got %0d pulses expected 0", drop_cnt_b - d0);
    end
    cfg_read(1'b1, 8'h40, 16'h1111, "conflict_b");
  endtask

  task automatic test_out_of_range;
    int d0;
    cfg_op(1'b1, 1'b1, 8'h10, 16'h5A5A, "cfg_wr_10");
    d0 = drop_cnt_b;
    ser_frame(1'b1, 1'b1, 8'h90, 16'h7777);
    repeat (4) @(posedge clk); #1;
    n_tests++;
    if (drop_cnt_b != d0 + 1) begin
      n_fail++; $display("FAIL oor_drop: got %0d pulses expected 1", drop_cnt_b - d0);
    end
    cfg_read(1'b1, 8'h90, 16'h0000, "oor_rd_90");
    cfg_read(1'b1, 8'h10, 16'h5A5A, "oor_alias_10");
  endtask

  task automatic test_scl_read_and_reset;
    ser_frame(1'b1, 1'b0, 8'h12, 16'h0);
    push_read_exp(16'hBEEF);
    ser_observe(1'b1, 22, 1'b1, "ser_rd_b");
    n_tests++;
    if (busy_b !== 1'b0) begin
      n_fail++; $display("FAIL scl_rd_busy_end: got %b expected 0", busy_b);
    end
    ser_frame(1'b1, 1'b0, 8'h12, 16'h0);
    push_read_exp(16'hBEEF);
    ser_observe(1'b1, 8, 1'b0, "ser_rd_b_part");
    ser_exp_q.delete();
    #3 reset_n = 1'b0;
    #1;
    n_tests++;
    if (dut_b.sda_oe_q !== 1'b0 || busy_b !== 1'b0 || rdy_b !== 1'b0 || drop_b !== 1'b0 || rdata_b !== 16'h0) begin
      n_fail++; $display("FAIL midframe_reset: got oe %b busy %b rdy %b drop %b rdata %h expected 0 0 0 0 0000",
                         dut_b.sda_oe_q, busy_b, rdy_b, drop_b, rdata_b);
    end
    tb_oe = 1'b1; tb_sda = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    cfg_read(1'b0, 8'h12, 16'hBEEF, "array_kept_a");
  endtask

  initial begin
    reset_n = 1'b0; scl = 1'b0; cfg_req = 1'b0; cfg_cmd = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; tb_oe = 1'b1; tb_sda = 1'b1; sel_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_cfg_rw;
    test_serial_write;
    test_serial_read;
    test_conflict;
    test_out_of_range;
    test_scl_read_and_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
